// File: rtl/efi_pkg.sv
// Shared types and helpers for the trigger-wheel generator.
// twg_clamp works on 32-bit values, so PERIOD_W must not exceed 32.
package efi_pkg;

    localparam int unsigned TWG_IDX_W = 8;

    typedef enum logic [0:0] {
        TWG_IDLE = 1'b0,
        TWG_RUN  = 1'b1
    } twg_state_e;

    // Upper bound applied first so that lo wins when hi < lo.
    function automatic logic [31:0] twg_clamp(input logic [31:0] val,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
        logic [31:0] r;
        r = (val > hi) ? hi : val;
        r = (r < lo) ? lo : r;
        return r;
    endfunction

endpackage

// File: rtl/twg_period_sat.sv
// Combinational next-slot period: fixed-mode clamp of period_in, or ramp-mode
// saturating add of a signed step onto the current period.
module twg_period_sat
    import efi_pkg::*;
#(
    parameter int unsigned PERIOD_W   = 24,
    parameter int unsigned PERIOD_MIN = 4
) (
    input  logic                ramp_mode_i,
    input  logic                seed_i,
    input  logic [PERIOD_W-1:0] period_in_i,
    input  logic [PERIOD_W-1:0] period_cur_i,
    input  logic [PERIOD_W-1:0] period_step_i,
    input  logic [PERIOD_W-1:0] period_max_i,
    output logic [PERIOD_W-1:0] period_next_o
);

    logic [PERIOD_W:0]   sum;
    logic [PERIOD_W-1:0] raw;
    logic [PERIOD_W-1:0] hi;

    always_comb begin
        sum = {1'b0, period_cur_i} + {period_step_i[PERIOD_W-1], period_step_i};
        // With a negative step the top bit flags a negative result; otherwise overflow.
        if (!ramp_mode_i || seed_i) begin
            raw = period_in_i;
        end else if (sum[PERIOD_W] && period_step_i[PERIOD_W-1]) begin
            raw = PERIOD_W'(PERIOD_MIN);
        end else if (sum[PERIOD_W]) begin
            raw = period_max_i;
        end else begin
            raw = sum[PERIOD_W-1:0];
        end
        hi            = ramp_mode_i ? period_max_i : '1;
        period_next_o = PERIOD_W'(twg_clamp(32'(raw), 32'(PERIOD_MIN), 32'(hi)));
    end

endmodule

// File: rtl/trigger_wheel_gen.sv
// Parametrised crank trigger-wheel generator (TEETH_TOTAL-TEETH_MISSING) with fixed or
// ramping slot period. Define TWG_CAM_EN to add the 720-degree cam output.
module trigger_wheel_gen
    import efi_pkg::*;
#(
    parameter int unsigned TEETH_TOTAL   = 60,
    parameter int unsigned TEETH_MISSING = 2,
    parameter int unsigned PERIOD_W      = 24,
    parameter int unsigned PERIOD_MIN    = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 enable_i,
    input  logic                 ramp_mode_i,
    input  logic [PERIOD_W-1:0]  period_in_i,
    input  logic [PERIOD_W-1:0]  period_step_i,
    input  logic [PERIOD_W-1:0]  period_max_i,
    output logic                 vrin_o,
    output logic [TWG_IDX_W-1:0] tooth_idx_o,
    output logic                 rev_pulse_o,
`ifdef TWG_CAM_EN
    output logic                 cam_o,
`endif
    output logic [PERIOD_W-1:0]  period_cur_o
);

    localparam int unsigned          TeethReal = TEETH_TOTAL - TEETH_MISSING;
    localparam logic [TWG_IDX_W-1:0] LastIdx   = TWG_IDX_W'(TEETH_TOTAL - 1);

    twg_state_e           state_q;
    logic [PERIOD_W-1:0]  phase_q, phase_d;
    logic [PERIOD_W-1:0]  period_q, period_d;
    logic [TWG_IDX_W-1:0] tooth_q, tooth_d;
    logic                 vrin_q, vrin_d;
    logic                 rev_q;
    logic                 slot_end;
    logic                 wrap;
    logic [PERIOD_W-1:0]  period_nxt;
`ifdef TWG_CAM_EN
    logic                 rev_odd_q, rev_odd_d;
    logic                 cam_q;
`endif

    twg_period_sat #(
        .PERIOD_W   (PERIOD_W),
        .PERIOD_MIN (PERIOD_MIN)
    ) u_period_sat (
        .ramp_mode_i   (ramp_mode_i),
        .seed_i        (state_q == TWG_IDLE),
        .period_in_i   (period_in_i),
        .period_cur_i  (period_q),
        .period_step_i (period_step_i),
        .period_max_i  (period_max_i),
        .period_next_o (period_nxt)
    );

    // Inputs only reach the slot registers through period_nxt at a slot boundary.
    always_comb begin
        slot_end = (phase_q == period_q - PERIOD_W'(1));
        wrap     = slot_end && (tooth_q == LastIdx);
        phase_d  = slot_end ? '0 : phase_q + PERIOD_W'(1);
        period_d = slot_end ? period_nxt : period_q;
        tooth_d  = tooth_q;
        if (slot_end) begin
            tooth_d = wrap ? '0 : tooth_q + TWG_IDX_W'(1);
        end
        vrin_d = (32'(tooth_d) < TeethReal) && (phase_d < (period_d >> 1));
`ifdef TWG_CAM_EN
        rev_odd_d = rev_odd_q ^ wrap;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni || (state_q == TWG_RUN && !enable_i)) begin
            state_q   <= TWG_IDLE;
            phase_q   <= '0;
            period_q  <= '0;
            tooth_q   <= '0;
            vrin_q    <= 1'b0;
            rev_q     <= 1'b0;
`ifdef TWG_CAM_EN
            rev_odd_q <= 1'b0;
            cam_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                TWG_IDLE: begin
                    if (enable_i) begin
                        state_q   <= TWG_RUN;
                        phase_q   <= '0;
                        period_q  <= period_nxt;
                        tooth_q   <= '0;
                        vrin_q    <= 1'b1;
                        rev_q     <= 1'b1;
`ifdef TWG_CAM_EN
                        rev_odd_q <= 1'b0;
                        cam_q     <= 1'b1;
`endif
                    end
                end
                TWG_RUN: begin
                    phase_q   <= phase_d;
                    period_q  <= period_d;
                    tooth_q   <= tooth_d;
                    vrin_q    <= vrin_d;
                    rev_q     <= wrap;
`ifdef TWG_CAM_EN
                    rev_odd_q <= rev_odd_d;
                    cam_q     <= (tooth_d == '0) && !rev_odd_d;
`endif
                end
                default: state_q <= TWG_IDLE;
            endcase
        end
    end

    assign vrin_o       = vrin_q;
    assign tooth_idx_o  = tooth_q;
    assign rev_pulse_o  = rev_q;
    assign period_cur_o = period_q;
`ifdef TWG_CAM_EN
    assign cam_o        = cam_q;
`endif

endmodule

// File: tb/tb_trigger_wheel_gen.sv
// Self-checking bench for trigger_wheel_gen: directed table, hand sequences for slot
// boundaries and saturation, and randomized stimulus against a slot-level model.
module tb_trigger_wheel_gen;

    localparam int TT    = 60;
    localparam int TM    = 2;
    localparam int PW    = 8;
    localparam int PMIN  = 4;
    localparam int PMAXV = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset_n, en, ramp;
    logic [PW-1:0] pin, step, pmax;
    logic          vrin, rev;
    logic [7:0]    tooth;
    logic [PW-1:0] per;
`ifdef TWG_CAM_EN
    logic          cam;
`endif

    always #5 clk = ~clk;

    trigger_wheel_gen #(
        .TEETH_TOTAL   (TT),
        .TEETH_MISSING (TM),
        .PERIOD_W      (PW),
        .PERIOD_MIN    (PMIN)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (reset_n),
        .enable_i      (en),
        .ramp_mode_i   (ramp),
        .period_in_i   (pin),
        .period_step_i (step),
        .period_max_i  (pmax),
        .vrin_o        (vrin),
        .tooth_idx_o   (tooth),
        .rev_pulse_o   (rev),
`ifdef TWG_CAM_EN
        .cam_o         (cam),
`endif
        .period_cur_o  (per)
    );

    int checks = 0;
    int errors = 0;

    // Model state: whether running, slot index, cycle within slot, slot length, rev parity.
    int m_run = 0, m_tooth = 0, m_ph = 0, m_per = 0, m_odd = 0;
    bit m_rev = 0;

    function automatic int clampf(int x);
        int r = x;
        if (ramp && r > int'(pmax)) r = int'(pmax);
        if (r < PMIN) r = PMIN;
        return r;
    endfunction

    task automatic model_step();
        int nxt;
        if (!reset_n || (m_run == 1 && !en)) begin
            m_run = 0; m_tooth = 0; m_ph = 0; m_per = 0; m_odd = 0; m_rev = 0;
        end else if (m_run == 0) begin
            if (en) begin
                m_run = 1; m_per = clampf(int'(pin)); m_tooth = 0; m_ph = 0; m_odd = 0;
                m_rev = 1;
            end
        end else if (m_ph == m_per - 1) begin
            m_ph    = 0;
            m_tooth = (m_tooth + 1) % TT;
            if (m_tooth == 0) m_odd ^= 1;
            m_rev = (m_tooth == 0);
            if (ramp) begin
                nxt = m_per + int'($signed(step));
                if (nxt < 0) nxt = PMIN;
                else if (nxt > PMAXV) nxt = int'(pmax);
            end else begin
                nxt = int'(pin);
            end
            m_per = clampf(nxt);
        end else begin
            m_ph++;
            m_rev = 0;
        end
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: model advances on the same inputs the DUT samples, then outputs compared.
    task automatic tick();
        bit e_vrin, e_cam;
        @(posedge clk);
        model_step();
        #1;
        e_vrin = (m_run == 1) && (m_tooth < TT - TM) && (m_ph < m_per / 2);
        e_cam  = (m_run == 1) && (m_tooth == 0) && (m_odd == 0);
        checks++;
        if (vrin !== e_vrin || tooth !== 8'(m_tooth) || rev !== m_rev || per !== PW'(m_per)
`ifdef TWG_CAM_EN
            || cam !== e_cam
`endif
        ) begin
            errors++;
            $display("FAIL model t=%0t: got vrin=%b idx=%0d rev=%b per=%0d, expected vrin=%b idx=%0d rev=%b per=%0d cam=%b",
                     $time, vrin, tooth, rev, per, e_vrin, m_tooth, m_rev, m_per, e_cam);
        end
    endtask

    task automatic start(int p, bit rm, int st, int mx);
        reset_n = 1'b0; en = 1'b0; ramp = rm;
        pin = PW'(p); step = PW'(st); pmax = PW'(mx);
        tick();
        reset_n = 1'b1; en = 1'b1;
        tick();
    endtask

    task automatic run_until_change(output int n);
        logic [7:0] prev;
        prev = tooth;
        n = 0;
        do begin
            tick();
            n++;
        end while (tooth == prev && n < 2000);
        if (tooth == prev) begin
            checks++;
            errors++;
            $display("FAIL slot timeout: tooth stuck at %0d, expected change within 2000 clks", tooth);
        end
    endtask

    typedef struct {
        bit rst_n;
        bit en;
        int pin;
        bit e_vrin;
        int e_tooth;
        bit e_rev;
        int e_per;
    } vec_t;

    vec_t tbl[$];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, highs, cnt;
        int exp_up[8]  = '{20, 22, 24, 26, 28, 30, 30, 30};
        int exp_dn[4]  = '{12, 7, 4, 4};
        int exp_ovf[3] = '{250, 255, 255};

        // Reset held with enable high, start, one 10-clk slot, drop, restart at clamped period.
        tbl.push_back('{0, 1, 10, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 10, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 10, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 10, 1, 0, 1, 10});
        for (int i = 0; i < 4; i++) tbl.push_back('{1, 1, 10, 1, 0, 0, 10});
        for (int i = 0; i < 5; i++) tbl.push_back('{1, 1, 10, 0, 0, 0, 10});
        tbl.push_back('{1, 1, 10, 1, 1, 0, 10});
        tbl.push_back('{1, 0, 10, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 2, 1, 0, 1, 4});
        tbl.push_back('{1, 1, 2, 1, 0, 0, 4});
        tbl.push_back('{1, 1, 2, 0, 0, 0, 4});
        tbl.push_back('{1, 1, 2, 0, 0, 0, 4});
        tbl.push_back('{1, 1, 2, 1, 1, 0, 4});
        tbl.push_back('{0, 0, 2, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 2, 0, 0, 0, 0});

        ramp = 1'b0; step = '0; pmax = PW'(50);
        reset_n = 1'b0; en = 1'b1; pin = PW'(10);
        foreach (tbl[i]) begin
            reset_n = tbl[i].rst_n;
            en      = tbl[i].en;
            pin     = PW'(tbl[i].pin);
            tick();
            check($sformatf("vec%0d vrin", i), int'(vrin), int'(tbl[i].e_vrin));
            check($sformatf("vec%0d tooth_idx", i), int'(tooth), tbl[i].e_tooth);
            check($sformatf("vec%0d rev_pulse", i), int'(rev), int'(tbl[i].e_rev));
            check($sformatf("vec%0d period_cur", i), int'(per), tbl[i].e_per);
        end

        // Ramp up with clamp at period_max.
        start(20, 1'b1, 2, 30);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) run_until_change(n);
            check($sformatf("ramp_up slot%0d period", k), int'(per), exp_up[k]);
        end

        // Ramp down, clamped at PERIOD_MIN.
        start(12, 1'b1, -5, 30);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) run_until_change(n);
            check($sformatf("ramp_dn slot%0d period", k), int'(per), exp_dn[k]);
        end

        // Add overflow saturates to period_max.
        start(250, 1'b1, 10, 255);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) run_until_change(n);
            check($sformatf("ramp_ovf slot%0d period", k), int'(per), exp_ovf[k]);
        end

        // Negative add saturates to PERIOD_MIN, not a wrapped value.
        start(4, 1'b1, -100, 200);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) run_until_change(n);
            check($sformatf("ramp_neg slot%0d period", k), int'(per), PMIN);
        end

        // period_max below PERIOD_MIN: PERIOD_MIN wins.
        start(10, 1'b1, 0, 2);
        check("pmax_low start period", int'(per), PMIN);
        run_until_change(n);
        check("pmax_low next period", int'(per), PMIN);

        // Mid-slot period_in change only affects the next slot.
        start(10, 1'b0, 0, 0);
        repeat (3) tick();
        pin = PW'(40);
        run_until_change(n);
        check("mid-slot change: current slot length", n + 3, 10);
        check("mid-slot change: next period", int'(per), 40);
        run_until_change(n);
        check("mid-slot change: next slot length", n, 40);

        // Enable dropped mid-slot 17, then restarted.
        start(10, 1'b0, 0, 0);
        for (int k = 0; k < 17; k++) run_until_change(n);
        check("drop: reached slot", int'(tooth), 17);
        repeat (4) tick();
        en = 1'b0;
        tick();
        check("drop: vrin", int'(vrin), 0);
        check("drop: tooth_idx", int'(tooth), 0);
        check("drop: period_cur", int'(per), 0);
        en = 1'b1;
        tick();
        check("restart: rev_pulse", int'(rev), 1);
        check("restart: tooth_idx", int'(tooth), 0);
        check("restart: vrin", int'(vrin), 1);
        check("restart: period_cur", int'(per), 10);

        // Full 60-2 revolution at period 10.
        start(10, 1'b0, 0, 0);
        n = 0;
        highs = vrin ? 1 : 0;
        do begin
            tick();
            n++;
            if (!rev) highs += int'(vrin);
        end while (!rev && n < 1000);
        check("rev: clocks between rev_pulse", n, 600);
        check("rev: vrin high clocks per rev", highs, (TT - TM) * 5);

`ifdef TWG_CAM_EN
        start(10, 1'b0, 0, 0);
        cnt = 0;
        for (int k = 0; k < 2 * TT * 10; k++) begin
            cnt += int'(cam);
            tick();
        end
        check("cam: high clocks over two revs", cnt, 10);
`else
        cnt = 0;
`endif

        // Randomized inputs, including mid-slot changes, enable drops and resets.
        start(8, 1'b0, 0, 20);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                ramp = 1'($urandom_range(0, 1));
                pin  = PW'($urandom_range(0, 16));
                step = PW'(int'($urandom_range(0, 12)) - 6);
                pmax = PW'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 299) == 0) en = ~en;
            reset_n = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
